// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types and constants for the SRAM read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam int N_CLIENTS       = 16;
  localparam int ADDR_W          = 19;
  localparam int MAX_PRIO_STREAK = 4;

  typedef logic [3:0] client_id_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // One-hot vector for a client id.
  function automatic logic [N_CLIENTS-1:0] id_onehot(input client_id_t id);
    return N_CLIENTS'(1) << id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first asserted
//               request strictly after the pointer, wrapping around, with the
//               pointer's own slot considered last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import mem_ctrl_pkg::*;
(
  input  logic [N_CLIENTS-1:0] i_req,
  input  client_id_t           i_ptr,
  output client_id_t           o_winner,
  output logic                 o_found
);

  client_id_t w_idx;

  // Scan from the farthest slot back towards ptr+1 so the nearest requester
  // after the pointer is the last one written. The 4-bit id add wraps modulo
  // the 16 clients.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int i = N_CLIENTS; i >= 1; i--) begin
      w_idx = i_ptr + client_id_t'(i);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
      end
    end
  end

  assign o_found = |i_req;

endmodule
`default_nettype wire

// File: rtl/sram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_rd_arbiter
// Description : Shares one SRAM read port among 16 clients. Each grant issues
//               a BURST_LEN burst of consecutive reads; read data is tagged
//               with a per-client valid RD_LAT cycles after each read strobe.
//               Optional macro SRAM_RD_ARB_STARVE_EN limits consecutive
//               contested priority-client wins to MAX_PRIO_STREAK.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [4:0]                          client_priority,
  input  logic [N_CLIENTS-1:0]                client_read_req,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0]    client_read_addr,
  output logic [N_CLIENTS-1:0]                client_gnt,
  output logic [N_CLIENTS-1:0]                client_rvalid,
  output logic                                sram_rd_en,
  output logic [ADDR_W-1:0]                   sram_rd_addr,
  output logic                                busy
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_e             r_state, w_state_nxt;
  logic [BEAT_W-1:0]      r_beat, w_beat_nxt;
  logic [ADDR_W-1:0]      r_base, w_base_nxt;
  client_id_t             r_winner, w_winner_nxt;
  client_id_t             r_last_winner, w_last_nxt;

  logic                   w_decide;
  logic                   w_prio_req;
  logic                   w_prio_win;
  client_id_t             w_prio_id;
  client_id_t             w_rr_id;
  logic                   w_rr_found;
  client_id_t             w_pick;

  logic [RD_LAT-1:0]      r_pipe_vld;
  client_id_t [RD_LAT-1:0] r_pipe_id;

  // A new winner may be chosen from IDLE or on the last beat of a burst.
  assign w_decide   = (r_state == IDLE) || (r_beat == LAST_BEAT);
  assign w_prio_id  = client_priority[3:0];
  assign w_prio_req = !client_priority[4] && client_read_req[w_prio_id];

  rr_pick u_rr_pick (
    .i_req    (client_read_req),
    .i_ptr    (r_last_winner),
    .o_winner (w_rr_id),
    .o_found  (w_rr_found)
  );

`ifdef SRAM_RD_ARB_STARVE_EN
  localparam int STREAK_W = $clog2(MAX_PRIO_STREAK + 1);

  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic                w_others_req;

  assign w_others_req = |(client_read_req & ~id_onehot(w_prio_id));
  assign w_prio_win   = w_prio_req && (r_streak < STREAK_W'(MAX_PRIO_STREAK));

  // Count contested priority wins; any round-robin win restarts the count.
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_decide && w_rr_found) begin
      if (w_prio_win) begin
        if (w_others_req) begin
          w_streak_nxt = r_streak + STREAK_W'(1);
        end
      end else begin
        w_streak_nxt = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end
`else
  assign w_prio_win = w_prio_req;
`endif

  assign w_pick = w_prio_win ? w_prio_id : w_rr_id;

  // Next-state: latch winner and base on a decision, otherwise step the beat.
  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_beat + BEAT_W'(1);
    w_base_nxt   = r_base;
    w_winner_nxt = r_winner;
    w_last_nxt   = r_last_winner;
    if (w_decide) begin
      w_beat_nxt = '0;
      if (w_rr_found) begin
        w_state_nxt  = BURST;
        w_winner_nxt = w_pick;
        w_base_nxt   = client_read_addr[w_pick];
        // A priority win leaves the round-robin pointer untouched.
        if (!w_prio_win) begin
          w_last_nxt = w_rr_id;
        end
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  // FSM and burst context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_base        <= '0;
      r_winner      <= '0;
      r_last_winner <= client_id_t'(N_CLIENTS - 1);
    end else begin
      r_state       <= w_state_nxt;
      r_beat        <= w_beat_nxt;
      r_base        <= w_base_nxt;
      r_winner      <= w_winner_nxt;
      r_last_winner <= w_last_nxt;
    end
  end

  // Read-return tag pipeline: {valid, id} delayed by the SRAM latency.
  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe_vld <= '0;
          r_pipe_id  <= '0;
        end else begin
          r_pipe_vld[0] <= sram_rd_en;
          r_pipe_id[0]  <= r_winner;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe_vld <= '0;
          r_pipe_id  <= '0;
        end else begin
          r_pipe_vld <= {r_pipe_vld[RD_LAT-2:0], sram_rd_en};
          r_pipe_id  <= {r_pipe_id[RD_LAT-2:0], r_winner};
        end
      end
    end
  endgenerate

  // Outputs decode straight from state so reset clears them at once.
  assign busy          = (r_state == BURST);
  assign sram_rd_en    = busy;
  assign sram_rd_addr  = busy ? (r_base + ADDR_W'(r_beat)) : '0;
  assign client_gnt    = (busy && (r_beat == '0)) ? id_onehot(r_winner) : '0;
  assign client_rvalid = r_pipe_vld[RD_LAT-1] ? id_onehot(r_pipe_id[RD_LAT-1]) : '0;

endmodule
`default_nettype wire
